// File: rtl/uart_pkg.sv
// Shared encodings and state type for the configurable UART transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } tx_state_t;

  // Tick count for a 1.5-bit stop period.
  function automatic int unsigned os_3_2(input int unsigned os);
    return (os * 3) / 2;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with occupancy count; head word is visible on rd_data.
module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with transmit FIFO.
// Define UART_TX_BREAK_EN to add the break_req input and BREAK line state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX   = 8,
  parameter int OS         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              s_tick,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [DBIT_MAX-1:0]               wr_data,
  input  logic [3:0]                        cfg_dbits,
  input  logic [1:0]                        cfg_parity,
  input  logic [1:0]                        cfg_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                              break_req,
`endif
  output logic                              tx,
  output logic                              tx_done_tick,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int TW = $clog2(2 * OS);
  localparam int BW = $clog2(DBIT_MAX + 1);
  localparam logic [TW-1:0] T_BIT = TW'(OS - 1);
  localparam logic [TW-1:0] T_1P5 = TW'(os_3_2(OS) - 1);
  localparam logic [TW-1:0] T_2   = TW'(2 * OS - 1);

  tx_state_t             state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DBIT_MAX-1:0]   shift;
  logic [BW-1:0]         f_dbits;
  logic                  f_par_en;
  logic                  f_par_bit;
  logic [TW-1:0]         f_stop_last;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DBIT_MAX-1:0]   fifo_rd_data;
  logic                  pop;

  logic [BW-1:0]         dbits_clamped;
  logic                  par_en_sel;
  logic                  head_parity;
  logic [TW-1:0]         stop_last_sel;

`ifdef UART_TX_BREAK_EN
  localparam int BRW = $clog2(12 * OS);
  localparam logic [BRW-1:0] BRK_LAST = BRW'(12 * OS - 1);
  logic [BRW-1:0] brk_cnt;
  logic           brk_mark;
  assign pop = (state == IDLE) && !fifo_empty && !break_req;
`else
  assign pop = (state == IDLE) && !fifo_empty;
`endif

  assign wr_ready = !fifo_full;
  assign busy     = (state != IDLE);

  uart_tx_fifo #(
    .WIDTH (DBIT_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame parameters are resolved from the head word and current config at pop time.
  always_comb begin
    if (cfg_dbits < 4'd5)                 dbits_clamped = BW'(5);
    else if (cfg_dbits > 4'(DBIT_MAX))    dbits_clamped = BW'(DBIT_MAX);
    else                                  dbits_clamped = BW'(cfg_dbits);

    par_en_sel  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
    head_parity = (cfg_parity == PAR_ODD);
    for (int i = 0; i < DBIT_MAX; i++) begin
      if (i < int'(dbits_clamped)) head_parity = head_parity ^ fifo_rd_data[i];
    end

    case (cfg_stop)
      STOP_1:   stop_last_sel = T_BIT;
      STOP_1P5: stop_last_sel = T_1P5;
      STOP_2:   stop_last_sel = T_2;
      default:  stop_last_sel = T_2;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      f_dbits      <= '0;
      f_par_en     <= 1'b0;
      f_par_bit    <= 1'b0;
      f_stop_last  <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt      <= '0;
      brk_mark     <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;

      // The line reflects the state held before this edge.
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        PARITY:  tx <= f_par_bit;
`ifdef UART_TX_BREAK_EN
        BREAK:   tx <= brk_mark;
`endif
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state    <= BREAK;
            tick_cnt <= '0;
            brk_cnt  <= '0;
            brk_mark <= 1'b0;
          end else
`endif
          if (!fifo_empty) begin
            state       <= START;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= fifo_rd_data;
            f_dbits     <= dbits_clamped;
            f_par_en    <= par_en_sel;
            f_par_bit   <= head_parity;
            f_stop_last <= stop_last_sel;
          end
        end
        START: if (s_tick) begin
          if (tick_cnt == T_BIT) begin
            state    <= DATA;
            tick_cnt <= '0;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
        DATA: if (s_tick) begin
          if (tick_cnt == T_BIT) begin
            tick_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_cnt == f_dbits - 1'b1) begin
              bit_cnt <= '0;
              state   <= f_par_en ? PARITY : STOP;
            end else bit_cnt <= bit_cnt + 1'b1;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
        PARITY: if (s_tick) begin
          if (tick_cnt == T_BIT) begin
            state    <= STOP;
            tick_cnt <= '0;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
        STOP: if (s_tick) begin
          if (tick_cnt == f_stop_last) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            tx_done_tick <= 1'b1;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        // Low phase saturates at its minimum length, then a one-bit mark follows.
        BREAK: if (s_tick) begin
          if (!brk_mark) begin
            if (brk_cnt == BRK_LAST && !break_req) begin
              brk_mark <= 1'b1;
              tick_cnt <= '0;
            end else if (brk_cnt != BRK_LAST) brk_cnt <= brk_cnt + 1'b1;
          end else if (tick_cnt == T_BIT) begin
            state    <= IDLE;
            tick_cnt <= '0;
            brk_mark <= 1'b0;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected frames, a monitor decodes the line.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int OS = 16;
`ifdef UART_TX_BREAK_EN
  localparam int EXP_FRAMES = 18;
`else
  localparam int EXP_FRAMES = 17;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic [3:0] cfg_dbits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic [1:0] cfg_stop = 2'b00;
  logic       tx;
  logic       tx_done_tick;
  logic       busy;
  logic [3:0] fifo_count;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  uart_tx_cfg #(.DBIT_MAX(8), .OS(OS), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
`ifdef UART_TX_BREAK_EN
    .break_req    (break_req),
`endif
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         dbits;
    bit         par_en;
    bit         par_bit;
    int         stop_ticks;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] cfg_d;
    logic [1:0] cfg_p;
    logic [1:0] cfg_s;
    exp_t       e;
    int         div;
  } vec_t;

  exp_t sb[$];
  int   assertCount = 0;
  int   failCount = 0;
  int   doneCount = 0;
  int   framesDone = 0;
  bit   monPause = 1'b0;
  bit   monBusy = 1'b0;
  bit   tickEn = 1'b0;
  int   tickDiv = 1;
  logic tickSeen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // s_tick changes just after the rising edge so it is stable when sampled.
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tickEn) begin
        s_tick = (c == 0);
        c = (c + 1 >= tickDiv) ? 0 : c + 1;
      end else begin
        s_tick = 1'b0;
        c = 0;
      end
    end
  end

  always @(posedge clk) tickSeen <= s_tick;
  always @(negedge clk) if (tx_done_tick === 1'b1) doneCount++;

  // One line sample per consumed tick: tx after the edge shows the state that consumed it.
  task automatic getSample(output logic v, output bit aborted, output bit dn);
    aborted = 1'b0;
    v = 1'b1;
    dn = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!reset_n) begin
        aborted = 1'b1;
        return;
      end
      if (tickSeen) begin
        v = tx;
        dn = (tx_done_tick === 1'b1);
        return;
      end
    end
    assertCount++;
    failCount++;
    $display("[TB] FAIL sample_timeout: got no tick, expected a tick within 4000 clocks");
    aborted = 1'b1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic       v;
    logic       bitVal;
    bit         ab;
    bit         dn;
    logic [7:0] rx;
    int         glitch;
    int         stopCnt;
    forever begin
      @(negedge clk);
      if (reset_n && tickSeen && tx === 1'b0 && !monPause) begin
        monBusy = 1'b1;
        if (sb.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_frame: got a start bit, expected an idle line");
          do getSample(v, ab, dn); while (v !== 1'b1 && !ab);
        end else begin
          e = sb.pop_front();
          glitch = 0;
          ab = 1'b0;
          rx = '0;
          for (int k = 1; k < OS && !ab; k++) begin
            getSample(v, ab, dn);
            if (!ab && v !== 1'b0) glitch++;
          end
          for (int b = 0; b < e.dbits && !ab; b++) begin
            bitVal = 1'b0;
            for (int k = 0; k < OS && !ab; k++) begin
              getSample(v, ab, dn);
              if (k == 0) bitVal = v;
              else if (!ab && v !== bitVal) glitch++;
            end
            rx[b] = bitVal;
          end
          if (e.par_en && !ab) begin
            bitVal = 1'b0;
            for (int k = 0; k < OS && !ab; k++) begin
              getSample(v, ab, dn);
              if (k == 0) bitVal = v;
              else if (!ab && v !== bitVal) glitch++;
            end
            if (!ab) checkOutput("parity_bit", 32'(bitVal), 32'(e.par_bit));
          end
          stopCnt = 0;
          dn = 1'b0;
          while (!ab && !dn && stopCnt <= 3 * OS) begin
            getSample(v, ab, dn);
            if (!ab) begin
              stopCnt++;
              if (v !== 1'b1) glitch++;
            end
          end
          if (!ab) begin
            checkOutput("frame_data", 32'(rx), 32'(e.data));
            checkOutput("stop_ticks", 32'(stopCnt), 32'(e.stop_ticks));
            checkOutput("bit_stability", 32'(glitch), 32'd0);
            framesDone++;
          end
        end
        monBusy = 1'b0;
      end
    end
  end

  task automatic writeWord(input logic [7:0] d, input exp_t e);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    wr_data = d;
    wr_valid = 1'b1;
    for (int n = 0; n < 5000 && !acc; n++) begin
      acc = (wr_ready === 1'b1);
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 wr_valid = 1'b0;
    if (acc) sb.push_back(e);
    else begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL write_timeout: got wr_ready low for 5000 clocks, expected acceptance");
    end
  endtask

  task automatic waitIdle(input int budget);
    int quiet;
    quiet = 0;
    for (int n = 0; n < budget && quiet < 3; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && fifo_count == 0 && !monBusy && sb.size() == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL idle_timeout: got busy=%0b queued=%0d, expected idle within %0d clocks",
               busy, sb.size(), budget);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    cfg_dbits = v.cfg_d;
    cfg_parity = v.cfg_p;
    cfg_stop = v.cfg_s;
    tickDiv = v.div;
    writeWord(v.data, v.e);
    for (int n = 0; n < 100 && busy !== 1'b1; n++) @(negedge clk);
    checkOutput("busy_after_pop", 32'(busy), 32'd1);
    cfg_dbits = 4'd5;
    cfg_parity = 2'b10;
    cfg_stop = 2'b00;
    waitIdle(4000);
  endtask

  vec_t vecs[6];
  exp_t e8n1;

  initial begin
    int doneBefore;
    vecs[0] = '{8'h55, 4'd8,  2'b00, 2'b00, '{8'h55, 8, 1'b0, 1'b0, 16}, 1};
    vecs[1] = '{8'h03, 4'd7,  2'b01, 2'b10, '{8'h03, 7, 1'b1, 1'b0, 32}, 1};
    vecs[2] = '{8'h1F, 4'd5,  2'b10, 2'b01, '{8'h1F, 5, 1'b1, 1'b0, 24}, 1};
    vecs[3] = '{8'hE7, 4'd3,  2'b01, 2'b11, '{8'h07, 5, 1'b1, 1'b1, 32}, 1};
    vecs[4] = '{8'hC3, 4'd15, 2'b11, 2'b00, '{8'hC3, 8, 1'b0, 1'b0, 16}, 3};
    vecs[5] = '{8'h94, 4'd6,  2'b10, 2'b00, '{8'h14, 6, 1'b1, 1'b1, 16}, 2};

    #12;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("reset_done_tick", 32'(tx_done_tick), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tickEn = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] FIFO fill with ticks stopped");
    @(negedge clk);
    tickDiv = 1;
    tickEn = 1'b0;
    cfg_dbits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop = 2'b00;
    for (int i = 0; i < 9; i++) begin
      e8n1 = '{8'(i * 37 + 1), 8, 1'b0, 1'b0, 16};
      writeWord(8'(i * 37 + 1), e8n1);
    end
    @(negedge clk);
    checkOutput("fifo_full_count", 32'(fifo_count), 32'd8);
    checkOutput("fifo_full_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("start_held_no_tick", 32'(tx), 32'd0);
    tickEn = 1'b1;
    e8n1 = '{8'hF0, 8, 1'b0, 1'b0, 16};
    writeWord(8'hF0, e8n1);
    waitIdle(5000);

    $display("[TB] reset during data bits");
    e8n1 = '{8'hA5, 8, 1'b0, 1'b0, 16};
    writeWord(8'hA5, e8n1);
    e8n1 = '{8'h3C, 8, 1'b0, 1'b0, 16};
    writeWord(8'h3C, e8n1);
    repeat (OS * 4 + 8) @(negedge clk);
    checkOutput("pre_reset_count", 32'(fifo_count), 32'd1);
    doneBefore = doneCount;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", 32'(tx), 32'd1);
    checkOutput("async_reset_count", 32'(fifo_count), 32'd0);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    checkOutput("no_done_on_abort", 32'(doneCount), 32'(doneBefore));
    reset_n = 1'b1;
    e8n1 = '{8'h5A, 8, 1'b0, 1'b0, 16};
    writeWord(8'h5A, e8n1);
    waitIdle(2000);

`ifdef UART_TX_BREAK_EN
    begin
      logic v;
      bit   ab;
      bit   dn;
      int   lowCnt;
      int   highCnt;
      $display("[TB] break with a queued frame");
      monPause = 1'b1;
      @(negedge clk);
      break_req = 1'b1;
      e8n1 = '{8'h81, 8, 1'b0, 1'b0, 16};
      writeWord(8'h81, e8n1);
      do getSample(v, ab, dn); while (v !== 1'b0 && !ab);
      lowCnt = 1;
      while (lowCnt < 299 && !ab) begin
        getSample(v, ab, dn);
        if (v === 1'b0) lowCnt++; else break;
      end
      break_req = 1'b0;
      do begin
        getSample(v, ab, dn);
        if (v === 1'b0) lowCnt++;
      end while (v === 1'b0 && !ab);
      checkOutput("break_low_300", 32'(lowCnt), 32'd300);
      monPause = 1'b0;
      highCnt = 1;
      do begin
        getSample(v, ab, dn);
        if (v === 1'b1) highCnt++;
      end while (v === 1'b1 && !ab && highCnt < 100);
      checkOutput("break_mark", 32'(highCnt), 32'(OS + 1));
      waitIdle(2000);

      $display("[TB] short break request");
      monPause = 1'b1;
      doneBefore = doneCount;
      @(negedge clk);
      break_req = 1'b1;
      do getSample(v, ab, dn); while (v !== 1'b0 && !ab);
      lowCnt = 1;
      while (lowCnt < 49 && !ab) begin
        getSample(v, ab, dn);
        if (v === 1'b0) lowCnt++; else break;
      end
      break_req = 1'b0;
      do begin
        getSample(v, ab, dn);
        if (v === 1'b0) lowCnt++;
      end while (v === 1'b0 && !ab);
      checkOutput("break_low_min", 32'(lowCnt), 32'd192);
      repeat (OS + 4) @(negedge clk);
      checkOutput("break_end_busy", 32'(busy), 32'd0);
      checkOutput("break_no_done", 32'(doneCount), 32'(doneBefore));
      monPause = 1'b0;
    end
`endif

    checkOutput("frames_completed", 32'(framesDone), 32'(EXP_FRAMES));
    checkOutput("done_pulses", 32'(doneCount), 32'(framesDone));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
